// File: rtl/mult_div_unit_pkg.sv
// Shared constants and state encoding for the multiply/divide unit.
// Imported by the unit top and its divide step.
package mult_div_unit_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ITER_COUNT = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MULT,
        S_DIV,
        S_WB
    } state_e;

endpackage

// File: rtl/mult_div_unit_div_step.sv
// One restoring-division iteration on unsigned magnitudes.
// Shifts one dividend bit into the remainder and trial-subtracts.
module div_restoring_step #(
    parameter int DATA_WIDTH = mult_div_unit_pkg::DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] rem_i,
    input  logic                  shift_in_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    output logic [DATA_WIDTH-1:0] rem_o,
    output logic                  q_o
);

    logic [DATA_WIDTH:0] trial;
    logic [DATA_WIDTH:0] diff;

    assign trial = {rem_i, shift_in_i};
    assign diff  = trial - {1'b0, divisor_i};
    assign q_o   = ~diff[DATA_WIDTH];
    assign rem_o = q_o ? diff[DATA_WIDTH-1:0] : trial[DATA_WIDTH-1:0];

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed MULT/DIV unit owning the HI and LO registers.
// Radix-2 Booth multiply and restoring divide, one bit per cycle.
module mult_div_unit #(
    parameter int DATA_WIDTH = mult_div_unit_pkg::DATA_WIDTH,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mult_start,
    input  logic                  div_start,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    output logic [DATA_WIDTH-1:0] HI_out,
    output logic [DATA_WIDTH-1:0] LO_out,
    output logic                  busy,
    output logic                  done,
    output logic                  div_zero
);
    import mult_div_unit_pkg::*;

    localparam int W = DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(ITER_COUNT - 1);

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    // Booth accumulator {A, Q, q-1}
    logic [2*W:0]         acc_q, acc_d;
    // Multiplicand, or divisor magnitude
    logic [W-1:0]         opb_q, opb_d;
    logic [W-1:0]         rem_q, rem_d;
    // Dividend bits shift out the top, quotient bits shift in below
    logic [W-1:0]         dvd_q, dvd_d;
    logic                 is_div_q, is_div_d;
    logic                 neg_q_q, neg_q_d;
    logic                 neg_r_q, neg_r_d;
    logic [W-1:0]         hi_q, hi_d;
    logic [W-1:0]         lo_q, lo_d;
    logic                 done_q, done_d;
    logic                 dz_q, dz_d;

    logic [W:0]           a_ext;
    logic [W:0]           m_ext;
    logic [W:0]           a_sum;
    logic [W-1:0]         rem_nxt;
    logic                 q_bit;

    // A is widened by one bit so that subtracting -2^(W-1) cannot overflow
    assign a_ext = {acc_q[2*W], acc_q[2*W:W+1]};
    assign m_ext = {opb_q[W-1], opb_q};

    // Booth add/subtract selected by the current and previous multiplier bit
    always_comb begin
        a_sum = a_ext;
        unique case (acc_q[1:0])
            2'b01:   a_sum = a_ext + m_ext;
            2'b10:   a_sum = a_ext - m_ext;
            default: a_sum = a_ext;
        endcase
    end

    div_restoring_step #(
        .DATA_WIDTH(W)
    ) u_div_step (
        .rem_i      (rem_q),
        .shift_in_i (dvd_q[W-1]),
        .divisor_i  (opb_q),
        .rem_o      (rem_nxt),
        .q_o        (q_bit)
    );

    // Next-state, datapath and result write-back
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        is_div_d = is_div_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dz_d     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (mult_start) begin
                    state_d  = S_MULT;
                    cnt_d    = '0;
                    acc_d    = {{W{1'b0}}, op_b, 1'b0};
                    opb_d    = op_a;
                    is_div_d = 1'b0;
                end else if (div_start && (op_b != '0)) begin
                    state_d  = S_DIV;
                    cnt_d    = '0;
                    rem_d    = '0;
                    dvd_d    = op_a[W-1] ? -op_a : op_a;
                    opb_d    = op_b[W-1] ? -op_b : op_b;
                    neg_q_d  = op_a[W-1] ^ op_b[W-1];
                    neg_r_d  = op_a[W-1];
                    is_div_d = 1'b1;
                end else if (div_start) begin
                    done_d = 1'b1;
                    dz_d   = 1'b1;
                end
            end
            S_MULT: begin
                acc_d = {a_sum, acc_q[W:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = S_WB;
                end
            end
            S_DIV: begin
                rem_d = rem_nxt;
                dvd_d = {dvd_q[W-2:0], q_bit};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                if (is_div_q) begin
                    lo_d = neg_q_q ? -dvd_q : dvd_q;
                    hi_d = neg_r_q ? -rem_q : rem_q;
                end else begin
                    hi_d = acc_q[2*W:W+1];
                    lo_d = acc_q[W:1];
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            rem_q    <= '0;
            dvd_q    <= '0;
            is_div_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            rem_q    <= rem_d;
            dvd_q    <= dvd_d;
            is_div_q <= is_div_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
        end
    end

    assign HI_out   = hi_q;
    assign LO_out   = lo_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = done_q;
    assign div_zero = dz_q;

endmodule
